result_serializer: RTL and testbench
====================================

RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (>=1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-006 SHALL have port res_data  input  8  result byte from the compute stage (combined uo_out).
REQ-007 SHALL have port res_valid  input  1  res_data valid this cycle.
REQ-008 SHALL have port res_ready  output  1  FIFO can accept a byte.
REQ-009 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-010 SHALL have port busy  output  1  FIFO non-empty or frame in progress.
REQ-011 SHALL have port overflow  output  1  sticky drop flag.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL drive res_ready = (level != DEPTH), combinational from registered state only.
REQ-014 SHALL push res_data on an edge where ena && res_valid && res_ready; write pointer wraps modulo DEPTH.
REQ-015 SHALL drop the byte and set overflow (held until reset) on an edge where ena && res_valid && !res_ready.
REQ-016 SHALL use FSM states IDLE, START, DATA, [PARITY], STOP; state, bit counter and cycle counter advance only when ena=1.
REQ-017 SHALL, in IDLE with level>0, pop the head on that edge into an 8-bit shift register and enter START; read pointer wraps modulo DEPTH.
REQ-018 SHALL hold each state for exactly CLKS_PER_BIT enabled cycles: START tx=0; DATA 8 bits LSB first; STOP tx=1.
REQ-019 SHALL, on the last STOP cycle, pop and enter START directly if level>0 (no idle gap), else enter IDLE.
REQ-020 SHALL keep level unchanged on an edge with a simultaneous push and pop.
REQ-021 SHALL give latency: a byte pushed into an empty FIFO while IDLE drives tx=0 starting two edges after the accepting edge.
REQ-022 SHALL drive busy = (state != IDLE) || (level != 0).
REQ-023 SHALL give frame length 10*CLKS_PER_BIT enabled cycles (11*CLKS_PER_BIT with parity).

Reset
REQ-024 SHALL, while rst=1, immediately force tx=1, busy=0, overflow=0, level=0, res_ready=1, state=IDLE, pointers and counters=0.
REQ-025 SHALL abort any frame in progress on reset and discard FIFO contents; tx returns high without completing the frame.
REQ-026 SHALL accept a push on the first enabled edge after rst deasserts.

Configuration
REQ-027 SHALL, with RESULT_SERIALIZER_PARITY_EN defined, insert a PARITY state between DATA and STOP driving the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-028 SHALL, without RESULT_SERIALIZER_PARITY_EN, omit the PARITY state entirely; DATA goes directly to STOP.

Verification
REQ-029 SHALL cover single byte: push 0xA5, CLKS_PER_BIT=4 -> tx low 2 edges later, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high, busy low after 40 cycles.
REQ-030 SHALL cover back-to-back: push 0x01,0x02,0x03 on consecutive cycles -> three frames with no idle cycle between stop and next start; level peaks at 2.
REQ-031 SHALL cover overflow: DEPTH=4, hold tx mid-frame, push 6 bytes -> res_ready low at level=4, 5th/6th dropped, overflow=1, only 5 bytes transmitted (1 in flight + 4 queued).
REQ-032 SHALL cover enable freeze: drop ena for 7 cycles mid-DATA -> tx, level and counters hold; frame resumes and completes 7 cycles late with correct bits.
REQ-033 SHALL cover reset mid-frame: assert rst during DATA with 2 bytes queued -> tx=1, level=0, busy=0, overflow=0 asynchronously; no residual bytes transmitted afterwards.
REQ-034 SHALL cover parity build: with RESULT_SERIALIZER_PARITY_EN, push 0x07 -> parity bit 1 for 4 cycles before stop; frame 44 cycles.

Source files
------------

// File: rtl/result_serializer.sv
// Result byte FIFO feeding an idle-high serial transmitter (start, 8 data bits LSB first, stop).
// Define RESULT_SERIALIZER_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module result_serializer #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [7:0]             res_data,
  input  logic                   res_valid,
  output logic                   res_ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_CYC   = CW'(CLKS_PER_BIT - 1);

`ifdef RESULT_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
`ifdef RESULT_SERIALIZER_PARITY_EN
  logic          par_bit;
`endif
  logic          push;
  logic          drop;
  logic          pop;
  logic          bit_done;
  logic          fifo_nonempty;
  logic [7:0]    head;

  assign res_ready     = (level != FULL_LEVEL);
  assign busy          = (state != IDLE) || (level != '0);
  assign fifo_nonempty = (level != '0);
  assign bit_done      = (cyc_cnt == LAST_CYC);
  assign push          = ena && res_valid && res_ready;
  assign drop          = ena && res_valid && !res_ready;
  // A pop happens exactly when the FSM loads a new byte: from IDLE, or at the end of STOP.
  assign pop           = ena && fifo_nonempty &&
                         ((state == IDLE) || ((state == STOP) && bit_done));
  assign head          = mem[rd_ptr];

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= res_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Transmit FSM; tx is registered from the current state, so it trails the state by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      tx      <= 1'b1;
`ifdef RESULT_SERIALIZER_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else if (ena) begin
      case (state)
        IDLE:    tx <= 1'b1;
        START:   tx <= 1'b0;
        DATA:    tx <= shreg[0];
`ifdef RESULT_SERIALIZER_PARITY_EN
        PARITY:  tx <= par_bit;
`endif
        STOP:    tx <= 1'b1;
        default: tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          if (fifo_nonempty) begin
            shreg <= head;
`ifdef RESULT_SERIALIZER_PARITY_EN
            par_bit <= ^head;
`endif
            state <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            bit_cnt <= 3'd0;
            state   <= DATA;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            shreg   <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef RESULT_SERIALIZER_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
`ifdef RESULT_SERIALIZER_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            state   <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            // Chain straight into the next frame when a byte is waiting.
            if (fifo_nonempty) begin
              shreg <= head;
`ifdef RESULT_SERIALIZER_PARITY_EN
              par_bit <= ^head;
`endif
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: begin
          cyc_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Directed self-checking bench for result_serializer (DEPTH=4, CLKS_PER_BIT=4).
// Honours RESULT_SERIALIZER_PARITY_EN to switch between 40- and 44-cycle frames.
module tb_result_serializer;

  localparam int CPB = 4;
`ifdef RESULT_SERIALIZER_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_T = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] level;

  int errors = 0;
  int checks = 0;

  result_serializer #(.DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .tx(tx), .busy(busy), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  // Line receiver: counts only enabled cycles, records bytes, frame starts and frame lengths.
  logic       ena_q = 1'b0;
  int         cyc = 0;
  int         tick_cnt = 0;
  bit         mon_busy = 1'b0;
  int         mon_t = 0;
  int         mon_start = 0;
  logic [7:0] mon_byte = 8'h00;
  int         bad_frames = 0;
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         len_q[$];

  always @(posedge clk) begin
    ena_q <= ena;
    cyc   <= cyc + 1;
  end

  always @(negedge clk) begin : monitor
    int idx;
    int ph;
    if (rst) begin
      mon_busy = 1'b0;
    end else if (ena_q) begin
      if (!mon_busy) begin
        if (tx == 1'b0) begin
          mon_busy  = 1'b1;
          mon_t     = 1;
          mon_start = cyc;
          mon_byte  = 8'h00;
          start_q.push_back(tick_cnt);
        end
      end else begin
        idx = mon_t / CPB;
        ph  = mon_t % CPB;
        if (ph == CPB / 2) begin
          if (idx >= 1 && idx <= 8) mon_byte[idx-1] = tx;
`ifdef RESULT_SERIALIZER_PARITY_EN
          if (idx == 9 && tx !== ^mon_byte) bad_frames++;
`endif
          if (idx == FRAME_BITS - 1 && tx !== 1'b1) bad_frames++;
        end
        if (mon_t == FRAME_T - 1) begin
          rx_q.push_back(mon_byte);
          len_q.push_back(cyc - mon_start);
          mon_busy = 1'b0;
        end else begin
          mon_t++;
        end
      end
      tick_cnt++;
    end
  end

  task automatic push_byte(input logic [7:0] d);
    res_data  = d;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string nm);
    int n = 0;
    while ((busy || mon_busy) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (busy || mon_busy) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", nm, max_cycles);
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
    len_q.delete();
    bad_frames = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({tx, busy, overflow, level, res_ready} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b ovf=%b level=%0d ready=%b, required 1 0 0 0 1",
               tx, busy, overflow, level, res_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [10:0] fb;
    logic        exp_b;
`ifdef RESULT_SERIALIZER_PARITY_EN
    fb = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    fb = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
    clear_rx();
    push_byte(8'hA5);
    checks++;
    if (level !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: level=%0d busy=%b, required 1 1", level, busy);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL single_latency_edge1: tx=%b, required 1", tx);
    end
    for (int k = 0; k < FRAME_T; k++) begin
      @(negedge clk);
      exp_b = fb[k / CPB];
      checks++;
      if (tx !== exp_b) begin
        errors++;
        $display("FAIL single_bit cycle %0d: tx=%b, required %b", k, tx, exp_b);
      end
    end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_end: busy=%b tx=%b, required 0 1", busy, tx);
    end
    wait_idle(20, "single_idle");
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_rx: got %0d bytes first=%h, required 1 byte a5", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [3];
    int peak = 0;
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
    clear_rx();
    res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res_data = exp_d[i];
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
    end
    res_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
    end
    checks++;
    if (peak != 2) begin
      errors++;
      $display("FAIL b2b_peak: level peak=%0d, required 2", peak);
    end
    wait_idle(4 * FRAME_T, "b2b_idle");
    checks++;
    if (rx_q.size() != 3 || bad_frames != 0) begin
      errors++;
      $display("FAIL b2b_count: frames=%0d bad=%0d, required 3 0", rx_q.size(), bad_frames);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL b2b_byte %0d: got %h, required %h", i, rx_q[i], exp_d[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (start_q[i] - start_q[i-1] != FRAME_T) begin
          errors++;
          $display("FAIL b2b_gap %0d: start spacing=%0d, required %0d", i,
                   start_q[i] - start_q[i-1], FRAME_T);
        end
      end
    end
  endtask

  task automatic test_enable_freeze();
    logic       tx_hold;
    logic [2:0] lvl_hold;
    clear_rx();
    push_byte(8'h5A);
    push_byte(8'hC3);
    repeat (19) @(negedge clk);
    ena       = 1'b0;
    res_valid = 1'b1;
    res_data  = 8'hFF;
    tx_hold   = tx;
    lvl_hold  = level;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== tx_hold || level !== lvl_hold) begin
        errors++;
        $display("FAIL freeze_hold %0d: tx=%b level=%0d, required %b %0d", i, tx, level,
                 tx_hold, lvl_hold);
      end
    end
    ena       = 1'b1;
    res_valid = 1'b0;
    wait_idle(4 * FRAME_T, "freeze_idle");
    checks++;
    if (rx_q.size() != 2 || bad_frames != 0) begin
      errors++;
      $display("FAIL freeze_count: frames=%0d bad=%0d, required 2 0", rx_q.size(), bad_frames);
    end else begin
      checks++;
      if (rx_q[0] !== 8'h5A || rx_q[1] !== 8'hC3) begin
        errors++;
        $display("FAIL freeze_bytes: got %h %h, required 5a c3", rx_q[0], rx_q[1]);
      end
      checks++;
      if (len_q[0] != FRAME_T - 1 + 7 || len_q[1] != FRAME_T - 1) begin
        errors++;
        $display("FAIL freeze_len: spans %0d %0d, required %0d %0d", len_q[0], len_q[1],
                 FRAME_T + 6, FRAME_T - 1);
      end
    end
  endtask

`ifdef RESULT_SERIALIZER_PARITY_EN
  task automatic test_parity();
    clear_rx();
    push_byte(8'h07);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 37) begin
        checks++;
        if (tx !== 1'b0) begin
          errors++;
          $display("FAIL parity_bit7: tx=%b, required 0", tx);
        end
      end
      if (k >= 38 && k <= 41) begin
        checks++;
        if (tx !== 1'b1) begin
          errors++;
          $display("FAIL parity_bit cycle %0d: tx=%b, required 1", k, tx);
        end
      end
    end
    wait_idle(FRAME_T, "parity_idle");
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h07 || len_q[0] != 43 || bad_frames != 0) begin
      errors++;
      $display("FAIL parity_frame: frames=%0d bad=%0d, required 1 byte 07 span 43 bad 0",
               rx_q.size(), bad_frames);
    end
  endtask
`endif

  task automatic test_overflow();
    logic [7:0] exp_d [5];
    exp_d[0] = 8'h11; exp_d[1] = 8'h21; exp_d[2] = 8'h22; exp_d[3] = 8'h23; exp_d[4] = 8'h24;
    clear_rx();
    push_byte(8'h11);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (res_ready !== (i < 4)) begin
        errors++;
        $display("FAIL ovf_ready push %0d: res_ready=%b, required %b", i, res_ready, (i < 4));
      end
      push_byte(8'h21 + 8'(i));
    end
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1 || res_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: level=%0d ovf=%b ready=%b, required 4 1 0", level, overflow,
               res_ready);
    end
    wait_idle(7 * FRAME_T, "ovf_idle");
    checks++;
    if (rx_q.size() != 5 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_count: frames=%0d ovf=%b, required 5 1", rx_q.size(), overflow);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL ovf_byte %0d: got %h, required %h", i, rx_q[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_rx();
    res_valid = 1'b1;
    res_data = 8'h33; @(negedge clk);
    res_data = 8'h44; @(negedge clk);
    res_data = 8'h55; @(negedge clk);
    res_valid = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (level !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: level=%0d busy=%b, required 2 1", level, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx, level, busy, overflow, res_ready} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_async: tx=%b level=%0d busy=%b ovf=%b ready=%b, required 1 0 0 0 1",
               tx, level, busy, overflow, res_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_rx();
    push_byte(8'h66);
    checks++;
    if (level !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_first_push: level=%0d, required 1", level);
    end
    wait_idle(3 * FRAME_T, "rstmid_idle");
    repeat (2 * FRAME_T) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h66 || tx !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_residual: frames=%0d tx=%b, required only byte 66 and tx 1",
               rx_q.size(), tx);
    end
  endtask

  initial begin
    rst       = 1'b1;
    ena       = 1'b1;
    res_valid = 1'b0;
    res_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_freeze();
`ifdef RESULT_SERIALIZER_PARITY_EN
    test_parity();
`endif
    test_overflow();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
